// File: rtl/cdc_req_ack_ctrl.sv
// Source-side 4-phase req/ack CDC controller with ack synchronizer.
// Optional phase watchdog enabled by defining CDC_TIMEOUT_EN.
module cdc_req_ack_ctrl #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_req,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ack,
  output logic              o_done,
  output logic [15:0]       o_count,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_sync;
  logic                   abort;

  assign ack_sync = sync_q[SYNC_STAGES-1];
  // A stale ack in IDLE must drain before a new request may start
  assign o_ready  = (state == IDLE) && !ack_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_ack};
  end

`ifdef CDC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wd        <= '0;
      abort     <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (i_valid && !ack_sync) abort <= 1'b0;
        end
        REQ: begin
          if (ack_sync) begin
            wd <= '0;
          end else if (wd == WD_LIM) begin
            wd        <= '0;
            abort     <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        REL: begin
          if (!ack_sync) begin
            wd <= '0;
          end else if (wd == WD_LIM) begin
            wd        <= '0;
            o_timeout <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: wd <= '0;
      endcase
    end
  end

  logic wd_hit;
  assign wd_hit = (wd == WD_LIM);
`else
  logic wd_hit;
  assign wd_hit    = 1'b0;
  assign abort     = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= IDLE;
      o_req   <= 1'b0;
      o_data  <= '0;
      o_done  <= 1'b0;
      o_count <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_valid && !ack_sync) begin
            o_data <= i_data;
            o_req  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ack_sync || wd_hit) begin
            o_req <= 1'b0;
            state <= REL;
          end
        end
        REL: begin
          // A timed-out request still waits for ack low but is not counted
          if (!ack_sync) begin
            state <= IDLE;
            if (!abort) begin
              o_done  <= 1'b1;
              o_count <= o_count + 16'd1;
            end
          end else if (wd_hit) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          o_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
